seq_operand_shifter: RTL

- Iterative barrel-shifter replacement that produces the shifted second operand for the datapath ALU's In2 input, plus the shifter carry-out.
- Shifts one bit per clock under a start/busy/done handshake, so the shift occupies extra multicycle states but needs no wide combinational shifter.
- Sits between the register-file read latch and the ALU In2 mux; the controller FSM waits on done before the execute state.

---
 rtl/seq_operand_shifter_pkg.sv | 16 +
 rtl/seq_operand_shifter_shift_step.sv | 42 ++++
 rtl/seq_operand_shifter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_operand_shifter_pkg.sv
// Shared constants for the iterative operand shifter: shift-type codes
// (also used by the instruction decoder) and the shifter FSM state encoding.
package seq_operand_shifter_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_operand_shifter_shift_step.sv
// Single-bit shift of a W-bit value by shift type, returning the shifted
// value and the bit shifted out. Purely combinational.
module seq_operand_shifter_shift_step
    import seq_operand_shifter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic [1:0]   i_type,
    output logic [W-1:0] o_val,
    output logic         o_carry
);

    // One-position shift and carry selection
    always_comb begin
        o_val   = i_val;
        o_carry = 1'b0;
        case (i_type)
            SH_LSL: begin
                o_val   = {i_val[W-2:0], 1'b0};
                o_carry = i_val[W-1];
            end
            SH_LSR: begin
                o_val   = {1'b0, i_val[W-1:1]};
                o_carry = i_val[0];
            end
            SH_ASR: begin
                o_val   = {i_val[W-1], i_val[W-1:1]};
                o_carry = i_val[0];
            end
            SH_ROR: begin
                o_val   = {i_val[0], i_val[W-1:1]};
                o_carry = i_val[0];
            end
            default: begin
                o_val   = i_val;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_operand_shifter.sv
// Iterative one-bit-per-clock operand shifter with start/busy/done handshake.
// Optional macro SHIFTER_RRX_EN turns ROR #0 into a one-cycle RRX.
module seq_operand_shifter
    import seq_operand_shifter_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     ShType,
    input  logic [SHW-1:0] ShAmt,
    input  logic [W-1:0]   In,
    input  logic           CarryIn,
    output logic [W-1:0]   Out,
    output logic           ShCarry,
    output logic           busy,
    output logic           done
);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_out;
    logic           r_carry;
    logic [1:0]     r_type;
    logic [SHW-1:0] r_cnt;
    logic           w_accept;
    logic           w_rrx_start;
    logic           w_pass;
    logic [W-1:0]   w_step_val;
    logic           w_step_carry;
    logic [W-1:0]   w_next_out;

    // A request is taken in IDLE or DONE; while shifting it is ignored.
    assign w_accept = start && (r_state != ST_SHIFT);

    seq_operand_shifter_shift_step #(.W(W)) u_step (
        .i_val   (r_out),
        .i_type  (r_type),
        .o_val   (w_step_val),
        .o_carry (w_step_carry)
    );

`ifdef SHIFTER_RRX_EN
    logic r_rrx;
    logic r_cin;

    assign w_rrx_start = (ShType == SH_ROR) && (ShAmt == {SHW{1'b0}});

    // RRX bookkeeping: remember the mode and the incoming carry at accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrx <= 1'b0;
            r_cin <= 1'b0;
        end else if (w_accept) begin
            r_rrx <= w_rrx_start;
            r_cin <= CarryIn;
        end else begin
            r_rrx <= r_rrx;
            r_cin <= r_cin;
        end
    end

    // RRX reuses the ROR step and replaces the rotated-in MSB with the old carry.
    assign w_next_out = r_rrx ? {r_cin, w_step_val[W-2:0]} : w_step_val;
`else
    assign w_rrx_start = 1'b0;
    assign w_next_out  = w_step_val;
`endif

    assign w_pass = (ShAmt == {SHW{1'b0}}) && !w_rrx_start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next = w_pass ? ST_DONE : ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SHIFT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: latch operands at accept, then shift one bit per SHIFT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= {W{1'b0}};
            r_carry <= 1'b0;
            r_type  <= 2'b00;
            r_cnt   <= {SHW{1'b0}};
        end else if (w_accept) begin
            r_out  <= In;
            r_type <= ShType;
            if (w_pass) begin
                r_carry <= CarryIn;
                r_cnt   <= {SHW{1'b0}};
            end else begin
                r_carry <= r_carry;
                r_cnt   <= w_rrx_start ? SHW'(1) : ShAmt;
            end
        end else if (r_state == ST_SHIFT) begin
            r_out   <= w_next_out;
            r_carry <= w_step_carry;
            r_cnt   <= r_cnt - SHW'(1);
        end else begin
            r_out   <= r_out;
            r_carry <= r_carry;
            r_type  <= r_type;
            r_cnt   <= r_cnt;
        end
    end

    assign Out     = r_out;
    assign ShCarry = r_carry;

endmodule
